updown_counter_ctrl: RTL
========================

// Module: updown_counter_ctrl
// PURPOSE
//  Parametrised up/down counter driven by active-low push-buttons. It is the generalised
//  successor of the 3-bit button counter: configurable width and count limits,
//  saturate or wrap mode, and synchronous load. Buttons are synchronised and edge-detected,
//  and a held button auto-repeats. Sits between the board button inputs and the display/LED logic.
// PARAMETERS
//  WIDTH        3   count width in bits
//  MIN_VAL      0   lowest count value; reset value of count
//  MAX_VAL      7   highest count value; legal if MIN_VAL < MAX_VAL <= 2**WIDTH-1
//  WRAP         0   0: saturate at limits; 1: wrap MAX_VAL<->MIN_VAL
//  SYNC_STAGES  2   button synchroniser depth (>=2)
//  RPT_DLY      8   cycles a press must be held before the first repeat step; 0 = repeat off
//  RPT_PER      4   cycles between repeat steps (>=1)
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous reset, active-low
//  up_n      in   1      up button, active-low, asynchronous to clk
//  down_n    in   1      down button, active-low, asynchronous to clk
//  load      in   1      synchronous load strobe, active-high
//  load_val  in   WIDTH  value to load; clamped to [MIN_VAL,MAX_VAL]
//  count     out  WIDTH  current count (registered)
//  full      out  1      count == MAX_VAL
//  empty     out  1      count == MIN_VAL
//  leds      out  1      sticky limit flag: last step was blocked (WRAP=0) or wrapped (WRAP=1)
// BEHAVIOUR
//  Reset (reset=0, async): count=MIN_VAL, leds=0, sync flops=1 (released), both button FSMs=IDLE,
//   repeat timers=0. full=(MIN_VAL==MAX_VAL)=0 and empty=1 during reset.
//  Sync: each button passes through SYNC_STAGES flops; s_up/s_dn = last stage, active-low.
//  Button FSM, one per button. States: IDLE, HOLD, RPT. Timer width: clog2(max(RPT_DLY,RPT_PER)+1).
//   IDLE: synced level low -> step request this cycle, timer=0, go to HOLD.
//   HOLD: released -> IDLE. RPT_DLY=0 -> stay in HOLD until released. Else timer++;
//         when timer==RPT_DLY-1 -> step request, timer=0, go to RPT.
//   RPT:  released -> IDLE. Else timer++; when timer==RPT_PER-1 -> step request, timer=0.
//   A button already low when reset is released counts as a new press.
//  Latency: count updates on the (SYNC_STAGES+1)th rising edge at which the button is sampled
//   low. Edge 1 is the first sample.
//  Count update priority (per cycle):
//   1. load=1: count=clamp(load_val), leds=0. Step requests this cycle are discarded.
//   2. up and down requests in the same cycle: no change to count or leds.
//   3. up request: count<MAX -> count+1, leds=0. count==MAX -> WRAP=0: hold, leds=1;
//      WRAP=1: count=MIN_VAL, leds=1.
//   4. down request: count>MIN -> count-1, leds=0. count==MIN -> WRAP=0: hold, leds=1;
//      WRAP=1: count=MAX_VAL, leds=1.
//  Arithmetic is WIDTH bits and is never allowed to overflow the range; the limit checks above
//   run before the add or subtract.
//  full and empty are combinational from the count register.
//  Reset mid-press or mid-repeat aborts immediately. No step is issued while reset=0.
// TESTING (defaults unless stated; edges counted from the first edge sampling the button low)
//  1. Release reset, pulse up_n low for 3 cycles -> count 0->1 at edge 3, exactly one step,
//     leds=0, empty 1->0.
//  2. Hold up_n low for 20 cycles from count 0 -> count=1 @edge3, 2 @edge11, 3 @edge15,
//     4 @edge19; release -> no further steps.
//  3. WRAP=0, count=7, press up -> count stays 7, full=1, leds=1. Then press down -> count=6,
//     full=0, leds=0.
//  4. WRAP=1, count=0, press down -> count=7, leds=1, full=1. Press up -> count=0, leds=1.
//  5. up_n and down_n fall on the same cycle at count=3 -> count stays 3, leds unchanged.
//     MAX_VAL=5: load=1, load_val=7 -> count=5, full=1.
//  6. Hold down_n at count=6 until the repeat phase starts, then pulse reset low for 1 cycle ->
//     count=0 and leds=0 asynchronously. With down_n still low, the next step is blocked at
//     MIN_VAL -> leds=1.

Source files
------------

// File: rtl/updown_counter_ctrl.sv
// Up/down counter driven by two active-low push-buttons.
// Each button is synchronised and edge-detected, and auto-repeats while held.
// Count range, saturate/wrap behaviour and repeat timing are parameters.
// A synchronous load with clamping overrides the buttons.
module updown_counter_ctrl #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned MIN_VAL     = 0,
    parameter int unsigned MAX_VAL     = 7,
    parameter int unsigned WRAP        = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RPT_DLY     = 8,
    parameter int unsigned RPT_PER     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_n,
    input  logic             down_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             leds
);

    localparam int unsigned TMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    // Timer values at which a step fires (compared before the increment).
    localparam logic [TW-1:0] DLY_LAST = TW'((RPT_DLY == 0) ? 0 : RPT_DLY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'((RPT_PER == 0) ? 0 : RPT_PER - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRpt
    } btn_state_e;

    // Index 0 is the up button, index 1 the down button.
    localparam int unsigned BTN_UP = 0;
    localparam int unsigned BTN_DN = 1;

    logic [SYNC_STAGES-1:0] up_sync_q;
    logic [SYNC_STAGES-1:0] dn_sync_q;
    logic [1:0]             btn_lvl;

    btn_state_e             btn_q [2];
    btn_state_e             btn_d [2];
    logic [TW-1:0]          tmr_q [2];
    logic [TW-1:0]          tmr_d [2];
    logic [1:0]             step_req;

    logic [WIDTH-1:0]       count_q;
    logic [WIDTH-1:0]       count_d;
    logic                   leds_q;
    logic                   leds_d;
    logic [WIDTH-1:0]       load_clamped;

    // Button synchronisers; reset to the released (high) level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_sync_q <= '1;
            dn_sync_q <= '1;
        end else begin
            up_sync_q <= {up_sync_q[SYNC_STAGES-2:0], up_n};
            dn_sync_q <= {dn_sync_q[SYNC_STAGES-2:0], down_n};
        end
    end

    assign btn_lvl[BTN_UP] = up_sync_q[SYNC_STAGES-1];
    assign btn_lvl[BTN_DN] = dn_sync_q[SYNC_STAGES-1];

    // Button FSM state and repeat timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                btn_q[b] <= StIdle;
                tmr_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                btn_q[b] <= btn_d[b];
                tmr_q[b] <= tmr_d[b];
            end
        end
    end

    // Button FSM next state: press edge, initial hold delay, then periodic repeat.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            btn_d[b]    = btn_q[b];
            tmr_d[b]    = tmr_q[b];
            step_req[b] = 1'b0;
            unique case (btn_q[b])
                StIdle: begin
                    if (!btn_lvl[b]) begin
                        step_req[b] = 1'b1;
                        tmr_d[b]    = '0;
                        btn_d[b]    = StHold;
                    end
                end
                StHold: begin
                    if (btn_lvl[b]) begin
                        btn_d[b] = StIdle;
                        tmr_d[b] = '0;
                    end else if (RPT_DLY != 0) begin
                        if (tmr_q[b] == DLY_LAST) begin
                            step_req[b] = 1'b1;
                            tmr_d[b]    = '0;
                            btn_d[b]    = StRpt;
                        end else begin
                            tmr_d[b] = tmr_q[b] + TW'(1);
                        end
                    end
                end
                StRpt: begin
                    if (btn_lvl[b]) begin
                        btn_d[b] = StIdle;
                        tmr_d[b] = '0;
                    end else if (tmr_q[b] == PER_LAST) begin
                        step_req[b] = 1'b1;
                        tmr_d[b]    = '0;
                    end else begin
                        tmr_d[b] = tmr_q[b] + TW'(1);
                    end
                end
                default: begin
                    btn_d[b] = StIdle;
                    tmr_d[b] = '0;
                end
            endcase
        end
    end

    // Clamp the load value into the legal count range.
    always_comb begin
        load_clamped = load_val;
        if (int'(load_val) < int'(MIN_VAL)) begin
            load_clamped = MIN_W;
        end else if (int'(load_val) > int'(MAX_VAL)) begin
            load_clamped = MAX_W;
        end
    end

    // Count next state: load beats buttons; simultaneous up+down is a no-op.
    // Limit checks come before the arithmetic so the count never leaves its range.
    always_comb begin
        count_d = count_q;
        leds_d  = leds_q;
        if (load) begin
            count_d = load_clamped;
            leds_d  = 1'b0;
        end else if (step_req[BTN_UP] && step_req[BTN_DN]) begin
            count_d = count_q;
        end else if (step_req[BTN_UP]) begin
            if (count_q == MAX_W) begin
                leds_d = 1'b1;
                if (WRAP != 0) begin
                    count_d = MIN_W;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
                leds_d  = 1'b0;
            end
        end else if (step_req[BTN_DN]) begin
            if (count_q == MIN_W) begin
                leds_d = 1'b1;
                if (WRAP != 0) begin
                    count_d = MAX_W;
                end
            end else begin
                count_d = count_q - WIDTH'(1);
                leds_d  = 1'b0;
            end
        end
    end

    // Count and limit-flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= MIN_W;
            leds_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            leds_q  <= leds_d;
        end
    end

    assign count = count_q;
    assign leds  = leds_q;
    assign full  = (count_q == MAX_W);
    assign empty = (count_q == MIN_W);

endmodule
